// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract unit with a running modular accumulator.
// Valid/ready on both sides; at most two beats are held internally.
module mod_addsub_pipe #(
   parameter int W = 4,
   parameter int M = 12
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [1:0]   op_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         clr_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] z_o,
   output logic         err_o
);

   localparam logic [W:0] MOD = (W+1)'(M);

   if (M < 2 || M > (1 << W)) begin : g_bad_modulus
      $error("mod_addsub_pipe: modulus M must satisfy 2 <= M <= 2**W");
   end

   // Applies the single conditional correction that brings a raw result into [0, M-1].
   function automatic logic [W-1:0] reduce(input logic [W:0] raw, input logic flag,
                                           input logic sub);
      logic [W:0] t;
      t = raw;
      if (flag) begin
         t = sub ? (raw + MOD) : (raw - MOD);
      end
      return t[W-1:0];
   endfunction

   logic           s1_valid_q, s1_valid_d;
   logic [W:0]     s1_raw_q, s1_raw_d;
   logic           s1_flag_q, s1_flag_d;
   logic           s1_sub_q, s1_sub_d;
   logic           s1_err_q, s1_err_d;
   logic           out_valid_q, out_valid_d;
   logic [W-1:0]   z_q, z_d;
   logic           err_q, err_d;
   logic [W-1:0]   acc_q, acc_d;

   logic           is_acc, is_sub;
   logic [W-1:0]   acc_prior, opa, opb;
   logic [W:0]     raw;
   logic           flag, in_err;
   logic           s2_load, in_fire;

   assign is_acc    = op_i[1];
   assign is_sub    = op_i[0];
   // A same-edge clear is applied before the accumulate op.
   assign acc_prior = clr_i ? '0 : acc_q;
   assign opa       = is_acc ? acc_prior : x_i;
   assign opb       = is_acc ? x_i : y_i;
   assign raw       = is_sub ? ({1'b0, opa} - {1'b0, opb}) : ({1'b0, opa} + {1'b0, opb});
   assign flag      = is_sub ? raw[W] : (raw >= MOD);
   assign in_err    = ({1'b0, x_i} >= MOD) || (!is_acc && ({1'b0, y_i} >= MOD));

   assign s2_load    = !out_valid_q || out_ready_i;
   assign in_ready_o = !s1_valid_q || s2_load;
   assign in_fire    = in_valid_i && in_ready_o;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_raw_d    = s1_raw_q;
      s1_flag_d   = s1_flag_q;
      s1_sub_d    = s1_sub_q;
      s1_err_d    = s1_err_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;
      err_d       = err_q;
      acc_d       = acc_q;

      if (in_ready_o) begin
         s1_valid_d = in_fire;
         if (in_fire) begin
            s1_raw_d  = raw;
            s1_flag_d = flag;
            s1_sub_d  = is_sub;
            s1_err_d  = in_err;
         end
      end

      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            z_d   = s1_err_q ? '0 : reduce(s1_raw_q, s1_flag_q, s1_sub_q);
            err_d = s1_err_q;
         end
      end

      if (clr_i) begin
         acc_d = '0;
      end
      if (in_fire && is_acc && !in_err) begin
         acc_d = reduce(raw, flag, is_sub);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         s1_raw_q    <= '0;
         s1_flag_q   <= 1'b0;
         s1_sub_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         out_valid_q <= 1'b0;
         z_q         <= '0;
         err_q       <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_raw_q    <= s1_raw_d;
         s1_flag_q   <= s1_flag_d;
         s1_sub_q    <= s1_sub_d;
         s1_err_q    <= s1_err_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign z_o         = z_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: an M=12 and an M=16 instance share one stimulus
// stream; each output beat is checked against a queued expectation.
module tb_mod_addsub_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [1:0] op = 2'd0;
   logic [3:0] x = 4'd0;
   logic [3:0] y = 4'd0;
   logic       clr = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready12, out_valid12, err12;
   logic [3:0] z12;
   logic       in_ready16, out_valid16, err16;
   logic [3:0] z16;

   always #5 clk = ~clk;

   mod_addsub_pipe #(.W(4), .M(12)) dut12 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready12),
      .op_i(op), .x_i(x), .y_i(y), .clr_i(clr), .out_valid_o(out_valid12),
      .out_ready_i(out_ready), .z_o(z12), .err_o(err12)
   );

   mod_addsub_pipe #(.W(4), .M(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready16),
      .op_i(op), .x_i(x), .y_i(y), .clr_i(clr), .out_valid_o(out_valid16),
      .out_ready_i(out_ready), .z_o(z16), .err_o(err16)
   );

   typedef struct {
      int z12;
      int e12;
      int z16;
      int e16;
      int cyc;
   } exp_t;

   typedef struct {
      bit       vld;
      bit [1:0] op;
      bit [3:0] x;
      bit [3:0] y;
      bit       clr;
      int       ez;
      int       ee;
   } vec_t;

   exp_t q[$];
   vec_t tbl[22];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   acc12 = 0;
   int   acc16 = 0;
   int   cyc = 0;
   bit   use_tbl = 0;
   bit   chk_lat = 0;
   int   t_z = 0;
   int   t_e = 0;
   bit   fired = 0;
   bit   stall_prev = 0;
   int   stall_z = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int mdl(input int m, input int o, input int a, input int b,
                              input int prior, output int err);
      err = (a >= m || (o < 2 && b >= m)) ? 1 : 0;
      if (err != 0) return 0;
      case (o)
         0:       return (a + b) % m;
         1:       return (a - b + m) % m;
         2:       return (prior + a) % m;
         default: return (prior - a + m) % m;
      endcase
   endfunction

   // One clock: evaluate handshakes at the falling edge, then step past the rising edge.
   task automatic cycle();
      exp_t e;
      int   zm12, em12, zm16, em16;
      @(negedge clk);
      fired = 0;
      if (stall_prev) begin
         chk("stall_hold_z", int'(z12), stall_z);
         chk("stall_hold_valid", int'(out_valid12), 1);
      end
      if (out_valid12 && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            e = q.pop_front();
            chk("z_m12", int'(z12), e.z12);
            chk("err_m12", int'(err12), e.e12);
            chk("valid_m16", int'(out_valid16), 1);
            chk("z_m16", int'(z16), e.z16);
            chk("err_m16", int'(err16), e.e16);
            if (chk_lat) chk("latency", cyc - e.cyc, 2);
         end
      end
      if (in_valid && in_ready12) begin
         fired = 1;
         zm12 = mdl(12, int'(op), int'(x), int'(y), clr ? 0 : acc12, em12);
         zm16 = mdl(16, int'(op), int'(x), int'(y), clr ? 0 : acc16, em16);
         e.z12 = use_tbl ? t_z : zm12;
         e.e12 = use_tbl ? t_e : em12;
         e.z16 = zm16;
         e.e16 = em16;
         e.cyc = cyc;
         q.push_back(e);
      end
      if (clr) begin
         acc12 = 0;
         acc16 = 0;
      end
      if (fired && op[1]) begin
         if (em12 == 0) acc12 = zm12;
         if (em16 == 0) acc16 = zm16;
      end
      stall_prev = out_valid12 && !out_ready;
      stall_z = int'(z12);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && q.size() != 0; i++) cycle();
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      tbl[0]  = '{1, 2'd0, 4'd7,  4'd9,  0, 4,  0};
      tbl[1]  = '{1, 2'd1, 4'd3,  4'd5,  0, 10, 0};
      tbl[2]  = '{1, 2'd0, 4'd11, 4'd11, 0, 10, 0};
      tbl[3]  = '{1, 2'd1, 4'd0,  4'd0,  0, 0,  0};
      tbl[4]  = '{1, 2'd2, 4'd5,  4'd0,  0, 5,  0};
      tbl[5]  = '{1, 2'd2, 4'd5,  4'd0,  0, 10, 0};
      tbl[6]  = '{1, 2'd2, 4'd5,  4'd0,  0, 3,  0};
      tbl[7]  = '{1, 2'd3, 4'd4,  4'd0,  0, 11, 0};
      tbl[8]  = '{1, 2'd2, 4'd4,  4'd0,  0, 3,  0};
      tbl[9]  = '{1, 2'd0, 4'd13, 4'd1,  0, 0,  1};
      tbl[10] = '{1, 2'd2, 4'd12, 4'd0,  0, 0,  1};
      tbl[11] = '{1, 2'd2, 4'd1,  4'd0,  0, 4,  0};
      tbl[12] = '{1, 2'd2, 4'd3,  4'd0,  0, 7,  0};
      tbl[13] = '{1, 2'd3, 4'd4,  4'd0,  1, 8,  0};
      tbl[14] = '{1, 2'd2, 4'd0,  4'd0,  0, 8,  0};
      tbl[15] = '{0, 2'd0, 4'd0,  4'd0,  1, 0,  0};
      tbl[16] = '{1, 2'd2, 4'd0,  4'd0,  0, 0,  0};
      tbl[17] = '{1, 2'd1, 4'd1,  4'd11, 0, 2,  0};
      tbl[18] = '{1, 2'd0, 4'd11, 4'd0,  0, 11, 0};
      tbl[19] = '{1, 2'd1, 4'd15, 4'd2,  0, 0,  1};
      tbl[20] = '{1, 2'd1, 4'd2,  4'd12, 0, 0,  1};
      tbl[21] = '{1, 2'd3, 4'd0,  4'd15, 0, 0,  0};

      // Power-on reset
      #2 rst_n = 1'b0;
      #3;
      chk("rst_out_valid", int'(out_valid12), 0);
      chk("rst_z", int'(z12), 0);
      chk("rst_err", int'(err12), 0);
      #7 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", int'(in_ready12), 1);

      // Directed table, back-to-back with the consumer always ready
      use_tbl = 1;
      chk_lat = 1;
      foreach (tbl[i]) begin
         in_valid = tbl[i].vld;
         op  = tbl[i].op;
         x   = tbl[i].x;
         y   = tbl[i].y;
         clr = tbl[i].clr;
         t_z = tbl[i].ez;
         t_e = tbl[i].ee;
         cycle();
         if (tbl[i].vld) chk("tbl_accept", int'(fired), 1);
      end
      in_valid = 1'b0;
      clr = 1'b0;
      drain();
      use_tbl = 0;

      // Full add/sub sweep over every 4-bit operand pair, model-checked on both moduli
      for (int o = 0; o < 2; o++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               in_valid = 1'b1;
               op = 2'(o);
               x  = 4'(a);
               y  = 4'(b);
               cycle();
            end
         end
      end
      in_valid = 1'b0;
      drain();
      chk_lat = 0;

      // Backpressure: consumer stalls for 4 cycles while 6 add beats are offered
      out_ready = 1'b0;
      begin
         int bp;
         int accepted;
         bp = 0;
         accepted = 0;
         for (int k = 0; k < 6; k++) begin
            int waits;
            in_valid = 1'b1;
            op = 2'd0;
            x  = 4'(k + 3);
            y  = 4'(2 * k);
            waits = 0;
            fired = 0;
            while (!fired && waits < 20) begin
               cycle();
               waits++;
               bp++;
               if (fired) accepted++;
               if (accepted == 2 && !out_ready && k == 1) begin
                  chk("in_ready_full", int'(in_ready12), 0);
               end
               if (bp == 4) out_ready = 1'b1;
            end
            if (!fired) chk("bp_accept_timeout", 0, 1);
         end
         in_valid = 1'b0;
         drain();
      end

      // Asynchronous reset with two beats in flight
      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 2'd2;
      x  = 4'd5;
      cycle();
      op = 2'd0;
      x  = 4'd7;
      y  = 4'd9;
      cycle();
      in_valid = 1'b0;
      chk("pre_reset_valid", int'(out_valid12), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid12), 0);
      chk("midrst_z", int'(z12), 0);
      chk("midrst_err", int'(err12), 0);
      q.delete();
      acc12 = 0;
      acc16 = 0;
      stall_prev = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_midrst", int'(in_ready12), 1);
      use_tbl = 1;
      t_z = 0;
      t_e = 0;
      in_valid = 1'b1;
      op = 2'd2;
      x  = 4'd0;
      cycle();
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mod_addsub_pipe.md
# mod_addsub_pipe

Pipelined, parametrised modular adder/subtractor with a valid/ready stream interface and a running modular accumulator. It generalises the 4-bit combinational modular add/sub datapath to W-bit operands, any modulus M with 2 ≤ M ≤ 2^W, registered two-stage operation with backpressure, accumulate modes and out-of-range operand detection. It sits between an operand source and a result consumer, both using valid/ready handshakes.

## Interface
- W, default 4: operand/result width in bits.
- M, default 12: modulus, compile-time constant; legal range 2 ≤ M ≤ 2^W (elaboration error otherwise).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- op  in  2  00 add, 01 sub, 10 acc_add, 11 acc_sub.
- x  in  W  first operand.
- y  in  W  second operand; ignored for acc ops.
- clr  in  1  clear accumulator (level, sampled each edge, no handshake).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- z  out  W  result, always in [0, M-1].
- err  out  1  qualifies z: operand out of range.

## Operation
- Transfer occurs on a rising edge where valid && ready; no beat is dropped or duplicated.
- add: z = (x + y) mod M. sub: z = (x − y) mod M, the non-negative residue.
- acc_add: acc ← (acc + x) mod M; z = new acc. acc_sub: acc ← (acc − x) mod M; z = new acc.
- acc is W bits, reset to 0, updated at the accept edge, fully reduced in stage 1. Back-to-back acc ops run at full throughput with no hazard.
- clr = 1 at an edge sets acc to 0. If an acc op is accepted at the same edge, it uses 0 as its prior acc: clear first, then apply.
- Range check: err = 1 if x ≥ M, or if y ≥ M for add/sub. On err, z = 0 and acc is left unchanged. A clr at the same edge still clears acc.
- Arithmetic widths:
  - Stage 1 forms a raw W+1-bit result: sum x+y for add, two's-complement x−y for sub.
  - Stage 1 also sets a correction flag: sum ≥ M for add, borrow for sub.
  - Stage 2 applies the correction: subtract M for add, add M for sub, then truncates to W bits.
  - With M = 2^W the result equals natural W-bit wrap.
- Pipeline:
  - Stage 1 register: s1_valid, raw, flag, err.
  - Stage 2 register: out_valid, z, err.
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 advances under the same condition.
  - in_ready = !s1_valid || (!out_valid || out_ready).
  - in_ready depends combinationally on out_ready; there is no other combinational input-to-output path.

## Timing
- Reset (rst_n low, asynchronous): s1_valid = 0, out_valid = 0, z = 0, err = 0, acc = 0.
- in_ready = 1 from the first cycle after reset release.
- Reset mid-stream discards all in-flight beats and acc immediately, with no partial output.
- Latency: a beat accepted at edge E0 is captured in stage 1 at E0 and in stage 2 at E1. z/out_valid are valid after E1, with no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: when out_valid && !out_ready, z and err hold stable. Stage 1 fills, then in_ready = 0 after a second beat is accepted. At most 2 beats are buffered.
- Simultaneous events:
  - At a stage-2 accept edge, stage 1 moves into stage 2 and a new beat can enter stage 1 at the same edge.
  - clr with no accepted acc op affects only acc; in-flight results are unchanged.
- Outputs change only on clk rising edges or on rst_n assertion.

## Test plan
1. Reset: assert rst_n low mid-stream with 2 beats in flight → out_valid = 0, z = 0, err = 0 immediately. After release, in_ready = 1, and acc_add x=0 returns z=0.
2. W=4, M=12, out_ready = 1, back-to-back add 7+9, sub 3−5, add 11+11, sub 0−0 → z = 4, 10, 10, 0 in order, each 2 edges after accept. Also run an exhaustive x, y < M sweep for both ops against the reference model; all 288 pass. Repeat with M = 16: 512 pass.
3. Accumulate, M=12: acc_add x=5 three times back-to-back → z = 5, 10, 3. Then acc_sub x=4 → z = 11.
4. clr and acc_sub x=4 accepted at the same edge with acc = 7 → z = 8, acc = 8.
5. Backpressure: stream 6 add beats with out_ready = 0 for 4 cycles. in_ready drops after 2 beats are accepted. z holds stable, and all 6 results emerge in order with none lost or duplicated.
6. Range error, M=12: add x=13, y=1 → err = 1, z = 0. Then acc_add x=12 with acc = 3 → err = 1, z = 0, acc stays 3. Next acc_add x=1 → z = 4, err = 0.
